instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory `address`. It captures the combinationally-read `instrucao` into an IF/ID register for the decoder.
- Selects one of three resident programs (fibonacci, factorial, synthetic) on a start pulse.
- Accepts stall and redirect (branch/jump) requests from decode/execute.

Parameters:
- ADDR_W, 10, width of the instruction address bus.
- MEM_LAST, 80, highest valid instruction word index.
- BASE_P0, 1, start address of program 0 (fibonacci).
- BASE_P1, 15, start address of program 1 (factorial).
- BASE_P2, 30, start address of program 2 (synthetic).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins execution of program_sel
- program_sel  in  2  program select; 0/1/2 valid, 3 illegal
- stall  in  1  hold PC and IF/ID register
- redirect_valid  in  1  branch taken or jump this cycle
- redirect_target  in  ADDR_W  absolute target word address
- halt_req  in  1  stop fetching
- address  out  ADDR_W  instruction memory address (= pc)
- instrucao  in  32  instruction word, combinational from memory
- if_instr  out  32  IF/ID instruction
- if_pc  out  ADDR_W  address of if_instr
- if_valid  out  1  if_instr is a real, non-squashed instruction
- running  out  1  high in FETCH state
- fetch_err  out  1  sticky; illegal program_sel or out-of-range PC
- fetch_count  out  16  fetched-instruction counter (optional feature)

Behaviour:
- Reset (async, reset==0):
  - state=IDLE; pc=0; if_instr=0; if_pc=0; if_valid=0; fetch_err=0; fetch_count=0.
  - address tracks pc, so it reads 0.
- States: IDLE, FETCH, HALT.
- IDLE:
  - if_valid=0.
  - start with program_sel 0/1/2: pc<=BASE_Px, next state FETCH.
  - start with program_sel==3: fetch_err<=1, stay IDLE.
- FETCH, per-cycle priority (highest first): halt_req > redirect_valid > stall > normal.
  - halt_req: next state HALT, if_valid<=0, pc holds.
  - redirect_valid, target<=MEM_LAST: pc<=redirect_target, if_valid<=0 (squashes the wrong-path word at the current pc). Redirect overrides a simultaneous stall.
  - redirect_valid, target>MEM_LAST: fetch_err<=1, next state HALT.
  - stall: pc, if_instr, if_pc, if_valid all hold.
  - normal: if_instr<=instrucao, if_pc<=pc, if_valid<=1, pc<=pc+1.
- Latency: the word at address A appears on if_instr one clock after pc==A.
- Boundary at pc==MEM_LAST: the word at MEM_LAST is captured normally; pc does not wrap, and next state is HALT.
- HALT:
  - if_valid=0 and running=0; pc holds.
  - start behaves as in IDLE: restart at the selected base. fetch_err clears only on reset.
- start while in FETCH is ignored.
- Reset asserted mid-fetch aborts immediately to the reset values; there is no drain.
- running=1 only in FETCH.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined: fetch_count increments, saturating at 16'hFFFF, on every cycle that sets if_valid<=1. It clears on reset and on an accepted start.
- Undefined: fetch_count is tied to 0 and no counter logic exists.

Decomposition:
- Package mips_fetch_pkg holds:
  - ADDR_W, MEM_LAST, BASE_P0..BASE_P2;
  - the fetch_state_t enum {IDLE, FETCH, HALT};
  - the program_sel encodings.
- One natural sub-module, fetch_next_pc: combinational next-PC/priority mux with outputs pc_next, squash and range_err. The top keeps the FSM and registers.

Test Plan:
- Reset low mid-run, then start, program_sel=0 → pc=1; if_pc=1 and if_valid=1 on the next clock; if_pc=2 the clock after.
- program_sel=1 start → address=15. Hold stall 3 cycles at pc=17 → if_pc/if_instr frozen, address stays 17; resumes at 18.
- FETCH at pc=24, redirect_valid with target=20 → one cycle if_valid=0, then if_pc=20.
- redirect_valid and stall together at pc=8, target=61 → redirect wins; pc=61 next clock.
- Redirect target=90 → fetch_err=1, HALT, running=0. Start with program_sel=2 → address=30, fetch_err stays 1.
- program_sel=3 start → fetch_err=1, stays IDLE. With FETCH_COUNT_EN, run program 0 until pc reaches 80 → HALT after capturing word 80; fetch_count=80.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// mips_fetch_pkg
// Shared constants and types for the instruction fetch unit:
//   ADDR_W            instruction address width
//   MEM_LAST          highest valid instruction word index
//   BASE_P0..BASE_P2  start addresses of the three resident programs
//   fetch_state_t     fetch FSM states
//   PSEL_*            program_sel encodings
//   program_base()    maps a legal program_sel to its start address
// ----------------------------------------------------------------------------
package mips_fetch_pkg;

  localparam int ADDR_W = 10;

  localparam logic [ADDR_W-1:0] MEM_LAST = 10'd80;
  localparam logic [ADDR_W-1:0] BASE_P0  = 10'd1;   // fibonacci
  localparam logic [ADDR_W-1:0] BASE_P1  = 10'd15;  // factorial
  localparam logic [ADDR_W-1:0] BASE_P2  = 10'd30;  // synthetic
  localparam logic [ADDR_W-1:0] PC_ONE   = 10'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam logic [1:0] PSEL_FIB     = 2'd0;
  localparam logic [1:0] PSEL_FACT    = 2'd1;
  localparam logic [1:0] PSEL_SYN     = 2'd2;
  localparam logic [1:0] PSEL_ILLEGAL = 2'd3;

  // Start address of the selected program; the illegal code maps to 0 and is
  // never used because the caller rejects it first.
  function automatic logic [ADDR_W-1:0] program_base(input logic [1:0] sel);
    logic [ADDR_W-1:0] base;
    case (sel)
      PSEL_FIB:  base = BASE_P0;
      PSEL_FACT: base = BASE_P1;
      PSEL_SYN:  base = BASE_P2;
      default:   base = 10'd0;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_if
// Bundles the fetch unit's control, memory and IF/ID signals.
//   start, program_sel       program launch request
//   stall, redirect_*        hold / branch requests from decode/execute
//   halt_req                 stop fetching
//   address, instrucao       instruction memory read port
//   if_instr, if_pc, if_valid  IF/ID register
//   running, fetch_err, fetch_count  status
// modport master: the fetch unit itself.  modport slave: its environment.
// ----------------------------------------------------------------------------
interface instruction_fetch_unit_if;
  import mips_fetch_pkg::*;

  logic              start;
  logic [1:0]        program_sel;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              halt_req;
  logic [ADDR_W-1:0] address;
  logic [31:0]       instrucao;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              if_valid;
  logic              running;
  logic              fetch_err;
  logic [15:0]       fetch_count;

  modport master (
    input  start, program_sel, stall, redirect_valid, redirect_target,
           halt_req, instrucao,
    output address, if_instr, if_pc, if_valid, running, fetch_err, fetch_count
  );

  modport slave (
    output start, program_sel, stall, redirect_valid, redirect_target,
           halt_req, instrucao,
    input  address, if_instr, if_pc, if_valid, running, fetch_err, fetch_count
  );

endinterface

// File: rtl/instruction_fetch_unit_next_pc.sv
// ----------------------------------------------------------------------------
// fetch_next_pc
// Combinational next-PC selection with the fetch priority
// halt_req > redirect_valid > stall > sequential.
//   inputs : state, pc, start, program_sel, halt_req, redirect_valid,
//            redirect_target, stall
//   outputs: pc_next   PC for the next cycle
//            squash    accepted redirect; the word at the current pc is dropped
//            range_err redirect target beyond MEM_LAST
// ----------------------------------------------------------------------------
module fetch_next_pc
  import mips_fetch_pkg::*;
(
  input  fetch_state_t      state,
  input  logic [ADDR_W-1:0] pc,
  input  logic              start,
  input  logic [1:0]        program_sel,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc_next,
  output logic              squash,
  output logic              range_err
);

  // Priority mux for the next PC and the redirect qualifiers.
  always_comb begin
    pc_next   = pc;
    squash    = 1'b0;
    range_err = 1'b0;
    case (state)
      FETCH: begin
        if (halt_req) begin
          pc_next = pc;
        end else if (redirect_valid) begin
          if (redirect_target <= MEM_LAST) begin
            pc_next = redirect_target;
            squash  = 1'b1;
          end else begin
            range_err = 1'b1;
          end
        end else if (stall) begin
          pc_next = pc;
        end else if (pc == MEM_LAST) begin
          // last word: capture it but do not wrap
          pc_next = pc;
        end else begin
          pc_next = pc + PC_ONE;
        end
      end
      IDLE, HALT: begin
        if (start && (program_sel != PSEL_ILLEGAL)) begin
          pc_next = program_base(program_sel);
        end else begin
          pc_next = pc;
        end
      end
      default: pc_next = pc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage: owns the PC, drives the instruction memory address and
// registers the returned word into the IF/ID register.
//   clock  system clock (rising edge)
//   reset  asynchronous, active-low
//   bus    instruction_fetch_unit_if.master (control, memory, IF/ID, status)
// Optional build macro FETCH_COUNT_EN enables the saturating fetch_count
// counter; without it fetch_count is tied to zero.
// ----------------------------------------------------------------------------
module instruction_fetch_unit
  import mips_fetch_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  fetch_state_t      state_r;
  fetch_state_t      state_next_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;
  logic              squash_s;
  logic              range_err_s;
  logic              start_ok_s;
  logic              capture_s;
  logic              if_valid_next_s;
  logic              err_set_s;
  logic [31:0]       if_instr_r;
  logic [ADDR_W-1:0] if_pc_r;
  logic              if_valid_r;
  logic              fetch_err_r;
  logic              running_r;

  // start is only honoured outside FETCH and with a legal program code
  assign start_ok_s = (state_r != FETCH) && bus.start && (bus.program_sel != PSEL_ILLEGAL);

  fetch_next_pc u_next_pc (
    .state           (state_r),
    .pc              (pc_r),
    .start           (bus.start),
    .program_sel     (bus.program_sel),
    .halt_req        (bus.halt_req),
    .redirect_valid  (bus.redirect_valid),
    .redirect_target (bus.redirect_target),
    .stall           (bus.stall),
    .pc_next         (pc_next_s),
    .squash          (squash_s),
    .range_err       (range_err_s)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, HALT: begin
        if (start_ok_s) state_next_s = FETCH;
        else            state_next_s = state_r;
      end
      FETCH: begin
        if (bus.halt_req)                     state_next_s = HALT;
        else if (range_err_s)                 state_next_s = HALT;
        else if (squash_s || bus.stall)       state_next_s = FETCH;
        else if (pc_r == MEM_LAST)            state_next_s = HALT;
        else                                  state_next_s = FETCH;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output decode: IF/ID capture, valid and error-set strobes.
  always_comb begin
    capture_s       = 1'b0;
    if_valid_next_s = 1'b0;
    err_set_s       = 1'b0;
    case (state_r)
      FETCH: begin
        if (bus.halt_req) begin
          if_valid_next_s = 1'b0;
        end else if (squash_s || range_err_s) begin
          if_valid_next_s = 1'b0;
          err_set_s       = range_err_s;
        end else if (bus.stall) begin
          if_valid_next_s = if_valid_r;
        end else begin
          capture_s       = 1'b1;
          if_valid_next_s = 1'b1;
        end
      end
      IDLE, HALT: begin
        if_valid_next_s = 1'b0;
        err_set_s       = bus.start && (bus.program_sel == PSEL_ILLEGAL);
      end
      default: if_valid_next_s = 1'b0;
    endcase
  end

  // PC, IF/ID register and status flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_r        <= 10'd0;
      if_instr_r  <= 32'd0;
      if_pc_r     <= 10'd0;
      if_valid_r  <= 1'b0;
      fetch_err_r <= 1'b0;
      running_r   <= 1'b0;
    end else begin
      pc_r        <= pc_next_s;
      if_valid_r  <= if_valid_next_s;
      fetch_err_r <= fetch_err_r | err_set_s;
      running_r   <= (state_next_s == FETCH);
      if (capture_s) begin
        if_instr_r <= bus.instrucao;
        if_pc_r    <= pc_r;
      end
    end
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count_r;

  // Saturating count of captured instructions, cleared by an accepted start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_count_r <= 16'd0;
    end else if (start_ok_s) begin
      fetch_count_r <= 16'd0;
    end else if (capture_s && (fetch_count_r != 16'hFFFF)) begin
      fetch_count_r <= fetch_count_r + 16'd1;
    end
  end

  assign bus.fetch_count = fetch_count_r;
`else
  assign bus.fetch_count = 16'h0000;
`endif

  assign bus.address   = pc_r;
  assign bus.if_instr  = if_instr_r;
  assign bus.if_pc     = if_pc_r;
  assign bus.if_valid  = if_valid_r;
  assign bus.running   = running_r;
  assign bus.fetch_err = fetch_err_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit. A cycle-level reference of the
// fetch rules predicts every output; literal expectations pin key points.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  instruction_fetch_unit_if bus_if ();

  instruction_fetch_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  // instruction memory contents: a tagged copy of the word address
  function automatic logic [31:0] mem_word(input int a);
    logic [31:0] w;
    w = 32'hC0DE0000 | (32'(a) & 32'h000003FF);
    return w;
  endfunction

  assign bus_if.instrucao = mem_word(int'(bus_if.address));

  // ---------------- reference model (0=idle 1=fetch 2=halt) ----------------
  int          m_state = 0;
  int          m_pc    = 0;
  logic [31:0] m_instr = 32'd0;
  int          m_ifpc  = 0;
  bit          m_valid = 1'b0;
  bit          m_err   = 1'b0;
  int          m_cnt   = 0;

  // advance the reference one clock from the current inputs
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_state <= 0; m_pc <= 0; m_instr <= 32'd0; m_ifpc <= 0;
      m_valid <= 1'b0; m_err <= 1'b0; m_cnt <= 0;
    end else if (m_state == 1) begin
      if (bus_if.halt_req) begin
        m_state <= 2; m_valid <= 1'b0;
      end else if (bus_if.redirect_valid) begin
        m_valid <= 1'b0;
        if (int'(bus_if.redirect_target) <= 80) m_pc <= int'(bus_if.redirect_target);
        else begin m_err <= 1'b1; m_state <= 2; end
      end else if (!bus_if.stall) begin
        m_instr <= mem_word(m_pc);
        m_ifpc  <= m_pc;
        m_valid <= 1'b1;
`ifdef FETCH_COUNT_EN
        m_cnt   <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
`endif
        if (m_pc == 80) m_state <= 2;
        else            m_pc <= m_pc + 1;
      end
    end else begin
      m_valid <= 1'b0;
      if (bus_if.start) begin
        if (bus_if.program_sel == 2'd3) m_err <= 1'b1;
        else begin
          m_state <= 1;
          m_cnt   <= 0;
          m_pc    <= (bus_if.program_sel == 2'd0) ? 1 : (bus_if.program_sel == 2'd1) ? 15 : 30;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare DUT against the reference every cycle, away from the clock edge
  always @(negedge clock) begin
    #1;
    chk("m_address",  32'(bus_if.address),     32'(m_pc));
    chk("m_running",  32'(bus_if.running),     32'(m_state == 1));
    chk("m_if_valid", 32'(bus_if.if_valid),    32'(m_valid));
    chk("m_if_pc",    32'(bus_if.if_pc),       32'(m_ifpc));
    chk("m_if_instr", bus_if.if_instr,         m_instr);
    chk("m_err",      32'(bus_if.fetch_err),   32'(m_err));
    chk("m_count",    32'(bus_if.fetch_count), 32'(m_cnt));
  end

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus_if.start = 1'b0; bus_if.program_sel = 2'd0; bus_if.stall = 1'b0;
    bus_if.redirect_valid = 1'b0; bus_if.redirect_target = 10'd0; bus_if.halt_req = 1'b0;
    #2 reset = 1'b0;
    step(); step();
    chk("rst_address", 32'(bus_if.address), 32'd0);
    chk("rst_valid",   32'(bus_if.if_valid), 32'd0);
    chk("rst_err",     32'(bus_if.fetch_err), 32'd0);
    reset = 1'b1;
    step();

    // program 0 start and first fetches
    bus_if.start = 1'b1; bus_if.program_sel = 2'd0;
    step();
    bus_if.start = 1'b0;
    chk("p0_address", 32'(bus_if.address), 32'd1);
    chk("p0_running", 32'(bus_if.running), 32'd1);
    step();
    chk("p0_if_pc1",  32'(bus_if.if_pc), 32'd1);
    chk("p0_valid1",  32'(bus_if.if_valid), 32'd1);
    step();
    chk("p0_if_pc2",  32'(bus_if.if_pc), 32'd2);
    chk("p0_instr2",  bus_if.if_instr, 32'hC0DE0002);

    // reset mid-run aborts immediately
    reset = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(bus_if.address), 32'd0);
    chk("mid_rst_run",  32'(bus_if.running), 32'd0);
    step();
    reset = 1'b1;
    step();

    // program 1 with a 3-cycle stall at pc 17
    bus_if.start = 1'b1; bus_if.program_sel = 2'd1;
    step();
    bus_if.start = 1'b0;
    chk("p1_address", 32'(bus_if.address), 32'd15);
    step(); step();
    bus_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", 32'(bus_if.address), 32'd17);
      chk("stall_ifpc", 32'(bus_if.if_pc), 32'd16);
    end
    bus_if.stall = 1'b0;
    step();
    chk("resume_ifpc", 32'(bus_if.if_pc), 32'd17);
    chk("resume_addr", 32'(bus_if.address), 32'd18);
    repeat (6) step();
    chk("pre_redir_addr", 32'(bus_if.address), 32'd24);

    // backward redirect squashes one word
    bus_if.redirect_valid = 1'b1; bus_if.redirect_target = 10'd20;
    step();
    bus_if.redirect_valid = 1'b0;
    chk("redir_addr",  32'(bus_if.address), 32'd20);
    chk("redir_valid", 32'(bus_if.if_valid), 32'd0);
    step();
    chk("redir_ifpc",  32'(bus_if.if_pc), 32'd20);

    // halt, restart program 0, redirect beats stall at pc 8
    bus_if.halt_req = 1'b1;
    step();
    bus_if.halt_req = 1'b0;
    chk("halt_run", 32'(bus_if.running), 32'd0);
    bus_if.start = 1'b1; bus_if.program_sel = 2'd0;
    step();
    bus_if.start = 1'b0;
    repeat (7) step();
    chk("pc8", 32'(bus_if.address), 32'd8);
    bus_if.stall = 1'b1; bus_if.redirect_valid = 1'b1; bus_if.redirect_target = 10'd61;
    step();
    bus_if.stall = 1'b0; bus_if.redirect_valid = 1'b0;
    chk("redir_stall_addr", 32'(bus_if.address), 32'd61);

    // out-of-range redirect then restart program 2
    step();
    bus_if.redirect_valid = 1'b1; bus_if.redirect_target = 10'd90;
    step();
    bus_if.redirect_valid = 1'b0;
    chk("range_err", 32'(bus_if.fetch_err), 32'd1);
    chk("range_run", 32'(bus_if.running), 32'd0);
    bus_if.start = 1'b1; bus_if.program_sel = 2'd2;
    step();
    bus_if.start = 1'b0;
    chk("p2_address", 32'(bus_if.address), 32'd30);
    chk("p2_err_sticky", 32'(bus_if.fetch_err), 32'd1);
    step();

    // illegal program select after a clean reset
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    bus_if.start = 1'b1; bus_if.program_sel = 2'd3;
    step();
    bus_if.start = 1'b0;
    chk("sel3_err", 32'(bus_if.fetch_err), 32'd1);
    chk("sel3_run", 32'(bus_if.running), 32'd0);

    // run program 0 to the end of memory
    bus_if.start = 1'b1; bus_if.program_sel = 2'd0;
    step();
    bus_if.start = 1'b0;
    for (int i = 0; i < 200 && bus_if.running; i++) step();
    chk("end_halted", 32'(bus_if.running), 32'd0);
    chk("end_ifpc",   32'(bus_if.if_pc), 32'd80);
    chk("end_addr",   32'(bus_if.address), 32'd80);
    chk("end_valid",  32'(bus_if.if_valid), 32'd1);
`ifdef FETCH_COUNT_EN
    chk("end_count",  32'(bus_if.fetch_count), 32'd80);
`else
    chk("end_count",  32'(bus_if.fetch_count), 32'd0);
`endif
    step();
    chk("end_valid_drop", 32'(bus_if.if_valid), 32'd0);
    chk("end_no_wrap",    32'(bus_if.address), 32'd80);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
